imem_loader: RTL and testbench

Boot-time program loader for the single-cycle core's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and drives the instruction-memory write port at sequential word addresses. It validates the image with a length header and an XOR checksum, and holds the core disabled until a good image is loaded. It is the write side of the instruction memory that fetch reads.

---
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time program loader for the instruction memory of the single-cycle
//   core. A byte stream arrives over a valid/ready handshake. The first byte is
//   a word count N. Then 4*N image bytes follow, little-endian within each word.
//   The last byte is an XOR checksum over the image bytes. Each assembled word
//   is written to sequential word addresses. The core stays disabled until a
//   complete image with a matching checksum has been loaded.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-low reset
//   start       single-cycle pulse; begins a load from IDLE, DONE or ERROR
//   in_valid    in_byte carries a stream byte this cycle
//   in_byte     stream byte
//   in_ready    loader accepts in_byte this cycle (HEADER, LOAD, CHECK)
//   wr_en       one-cycle instruction-memory write strobe
//   wr_addr     word address of the write
//   wr_data     word to write
//   core_en     enable for the core; high only in DONE
//   done        image loaded and verified
//   error       bad header or checksum mismatch
//   word_count  words written by the current or last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_en,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int          CNT_W = ADDR_W + 1;
  localparam logic [31:0] CAP   = 32'(1) << ADDR_W;

  typedef enum logic [2:0] {
    IDLE, HEADER, LOAD, CHECK, DONE, ERROR
  } state_t;

  state_t           state, nxt;
  logic [1:0]       byte_idx;
  logic [CNT_W-1:0] addr_cnt;
  logic [CNT_W-1:0] n_words;
  logic [7:0]       csum;
  logic [23:0]      word_buf;
  logic             hs;
  logic             hdr_bad;
  logic             last_byte_of_image;

  // in_ready is a registered copy of "state is HEADER/LOAD/CHECK", so hs
  // is an ordinary accepted-byte strobe.
  assign hs                 = in_valid & in_ready;
  assign hdr_bad            = (in_byte == 8'd0) || ({24'd0, in_byte} > CAP);
  assign last_byte_of_image = (byte_idx == 2'd3) && ((addr_cnt + 1'b1) == n_words);

  // Next-state decode. The registered status outputs below are derived from
  // nxt, so each one changes on the same edge as the state.
  always_comb begin
    // NOTE: default first, so that every path assigns nxt and no latch is inferred.
    nxt = state;
    unique case (state)
      IDLE, DONE, ERROR: if (start) nxt = HEADER;
      HEADER:            if (hs) nxt = hdr_bad ? ERROR : LOAD;
      LOAD:              if (hs && last_byte_of_image) nxt = CHECK;
      CHECK:             if (hs) nxt = (in_byte == csum) ? DONE : ERROR;
      default:           nxt = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      core_en    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
      byte_idx   <= '0;
      addr_cnt   <= '0;
      n_words    <= '0;
      csum       <= '0;
      word_buf   <= '0;
    end else begin
      state    <= nxt;
      in_ready <= (nxt == HEADER) || (nxt == LOAD) || (nxt == CHECK);
      core_en  <= (nxt == DONE);
      done     <= (nxt == DONE);
      error    <= (nxt == ERROR);
      wr_en    <= 1'b0;

      unique case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            word_count <= '0;
            byte_idx   <= '0;
            addr_cnt   <= '0;
            csum       <= '0;
          end
        end
        HEADER: begin
          if (hs && !hdr_bad) n_words <= CNT_W'(in_byte);
        end
        LOAD: begin
          if (hs) begin
            csum     <= csum ^ in_byte;
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: word_buf[7:0]   <= in_byte;
              2'd1: word_buf[15:8]  <= in_byte;
              2'd2: word_buf[23:16] <= in_byte;
              default: begin
                // The 4th byte goes straight into the write word, so there is
                // no bubble at word boundaries.
                wr_data    <= {in_byte, word_buf};
                wr_addr    <= addr_cnt[ADDR_W-1:0];
                wr_en      <= 1'b1;
                addr_cnt   <= addr_cnt + 1'b1;
                word_count <= word_count + 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader (ADDR_W = 5). Inputs are driven and outputs
//   sampled on the falling edge. A monitor records every write strobe seen
//   during a cycle, in order, for later comparison with hand-computed
//   expectations.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              core_en;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  int vectors     = 0;
  int miscompares = 0;

  // Write log
  logic [ADDR_W-1:0] log_addr [256];
  logic [31:0]       log_data [256];
  int                nw = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_en    (core_en),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // At the rising edge, wr_en still holds the value of the cycle that is ending.
  always @(posedge clk) begin
    if (wr_en === 1'b1 && nw < 256) begin
      log_addr[nw] = wr_addr;
      log_data[nw] = wr_data;
      nw++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Offer one byte until it is accepted (bounded), then drop in_valid.
  task automatic send(input logic [7:0] b);
    bit took;
    took     = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    for (int i = 0; i < 50 && !took; i++) begin
      took = (in_ready === 1'b1);
      cycle();
    end
    in_valid = 1'b0;
    check("handshake", 64'(took), 64'd1);
  endtask

  task automatic send_gap(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) cycle();
    send(b);
  endtask

  // Image 0x00000013, 0x00100093. The XOR of the eight image bytes is 0x90.
  logic [7:0] nom [9] = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

  task automatic check_nominal_writes(input int base, input string tag);
    check({tag, "_nw"},    64'(nw - base), 64'd2);
    check({tag, "_addr0"}, 64'(log_addr[base]), 64'd0);
    check({tag, "_data0"}, 64'(log_data[base]), 64'h0000_0013);
    check({tag, "_addr1"}, 64'(log_addr[base+1]), 64'd1);
    check({tag, "_data1"}, 64'(log_data[base+1]), 64'h0010_0093);
  endtask

  task automatic check_done(input string tag, input logic [ADDR_W:0] wc);
    check({tag, "_done"},    64'(done), 64'd1);
    check({tag, "_core_en"}, 64'(core_en), 64'd1);
    check({tag, "_error"},   64'(error), 64'd0);
    check({tag, "_wc"},      64'(word_count), 64'(wc));
  endtask

  initial begin
    int base;
    logic [7:0]  big_bytes [128];
    logic [7:0]  big_sum;
    logic [31:0] exp_word;

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;

    // ---- Reset values (asynchronous, before any clock edge) ----
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wr_en",    64'(wr_en), 64'd0);
    check("rst_wr_addr",  64'(wr_addr), 64'd0);
    check("rst_wr_data",  64'(wr_data), 64'd0);
    check("rst_core_en",  64'(core_en), 64'd0);
    check("rst_done",     64'(done), 64'd0);
    check("rst_error",    64'(error), 64'd0);
    check("rst_wc",       64'(word_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // ---- IDLE does not consume bytes ----
    in_valid = 1'b1; in_byte = 8'hAA;
    repeat (3) begin
      check("idle_in_ready", 64'(in_ready), 64'd0);
      cycle();
    end
    in_valid = 1'b0;
    check("idle_no_write", 64'(nw), 64'd0);

    // ---- Nominal load ----
    pulse_start();
    check("hdr_in_ready", 64'(in_ready), 64'd1);
    base = nw;
    for (int i = 0; i < 9; i++) send(nom[i]);
    // First CHECK cycle: last word's strobe.
    check("last_wr_en",    64'(wr_en), 64'd1);
    check("last_wr_addr",  64'(wr_addr), 64'd1);
    check("last_wr_data",  64'(wr_data), 64'h0010_0093);
    check("last_wc",       64'(word_count), 64'd2);
    check("check_ready",   64'(in_ready), 64'd1);
    send(8'h90);
    check_done("nom", 6'd2);
    check_nominal_writes(base, "nom");

    // ---- DONE does not consume bytes ----
    in_valid = 1'b1; in_byte = 8'h55;
    repeat (3) begin
      check("done_in_ready", 64'(in_ready), 64'd0);
      cycle();
    end
    in_valid = 1'b0;
    check("done_hold", 64'(done), 64'd1);
    check("done_no_write", 64'(nw - base), 64'd2);

    // ---- Restart from DONE ----
    pulse_start();
    check("rs_core_en",  64'(core_en), 64'd0);
    check("rs_done",     64'(done), 64'd0);
    check("rs_in_ready", 64'(in_ready), 64'd1);
    check("rs_wc",       64'(word_count), 64'd0);

    // ---- Bad checksum, with start held during LOAD bytes ----
    base = nw;
    send(nom[0]);
    start = 1'b1;
    for (int i = 1; i < 5; i++) send(nom[i]);
    start = 1'b0;
    for (int i = 5; i < 9; i++) send(nom[i]);
    send(8'h80);
    check("bad_error",   64'(error), 64'd1);
    check("bad_core_en", 64'(core_en), 64'd0);
    check("bad_done",    64'(done), 64'd0);
    check("bad_wc",      64'(word_count), 64'd2);
    check_nominal_writes(base, "bad");

    // ---- Recovery from ERROR ----
    pulse_start();
    base = nw;
    for (int i = 0; i < 9; i++) send(nom[i]);
    send(8'h90);
    check_done("recov", 6'd2);
    check_nominal_writes(base, "recov");

    // ---- Header N = 0 ----
    pulse_start();
    base = nw;
    send(8'd0);
    check("n0_error",   64'(error), 64'd1);
    check("n0_core_en", 64'(core_en), 64'd0);
    check("n0_ready",   64'(in_ready), 64'd0);
    cycle();
    check("n0_no_write", 64'(nw - base), 64'd0);

    // ---- Header N = 33 ----
    pulse_start();
    send(8'd33);
    check("n33_error", 64'(error), 64'd1);
    cycle();
    check("n33_no_write", 64'(nw - base), 64'd0);
    check("n33_wc",       64'(word_count), 64'd0);

    // ---- Header N = 32, full memory ----
    big_sum = 8'h00;
    for (int k = 0; k < 128; k++) begin
      big_bytes[k] = 8'(k * 7 + 3);
      big_sum      = big_sum ^ big_bytes[k];
    end
    pulse_start();
    base = nw;
    send(8'd32);
    for (int k = 0; k < 128; k++) send(big_bytes[k]);
    send(big_sum);
    check_done("n32", 6'd32);
    check("n32_nw", 64'(nw - base), 64'd32);
    for (int w = 0; w < 32; w++) begin
      exp_word = {big_bytes[4*w+3], big_bytes[4*w+2], big_bytes[4*w+1], big_bytes[4*w]};
      check("n32_addr", 64'(log_addr[base+w]), 64'(w));
      check("n32_data", 64'(log_data[base+w]), 64'(exp_word));
    end

    // ---- Gaps in in_valid ----
    pulse_start();
    base = nw;
    for (int i = 0; i < 9; i++) send_gap(nom[i]);
    send_gap(8'h90);
    check_done("gap", 6'd2);
    check_nominal_writes(base, "gap");

    // ---- Reset mid-load after 6 data bytes ----
    pulse_start();
    base = nw;
    for (int i = 0; i < 7; i++) send(nom[i]);
    check("pre_rst_wc", 64'(word_count), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("mr_in_ready", 64'(in_ready), 64'd0);
    check("mr_wr_en",    64'(wr_en), 64'd0);
    check("mr_wr_addr",  64'(wr_addr), 64'd0);
    check("mr_wr_data",  64'(wr_data), 64'd0);
    check("mr_core_en",  64'(core_en), 64'd0);
    check("mr_done",     64'(done), 64'd0);
    check("mr_error",    64'(error), 64'd0);
    check("mr_wc",       64'(word_count), 64'd0);
    @(negedge clk);
    in_valid = 1'b1; in_byte = 8'h00;
    repeat (4) cycle();
    in_valid = 1'b0;
    check("mr_no_write", 64'(nw - base), 64'd1);
    rst = 1'b1;
    cycle();

    // ---- Fresh load after reset ----
    pulse_start();
    base = nw;
    for (int i = 0; i < 9; i++) send(nom[i]);
    send(8'h90);
    check_done("fresh", 6'd2);
    check_nominal_writes(base, "fresh");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
